// File: rtl/if_pkg.sv
// if_pkg: shared types and constants for the instruction-fetch unit
package if_pkg;

    typedef enum logic [1:0] {ISSUE, WAIT, HOLD, DROP} fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam int          DEFAULT_PC_STEP  = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: owns the PC, fetches one instruction at a time over req/ack and feeds the IF/ID register
module if_fetch_unit
    import if_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
    parameter int                PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              id_stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [31:0]       IF_INSTRUCTION,
    output logic [ADDR_W-1:0] IF_NEXT_PC,
    output logic              IF_VALID,
    output logic [ADDR_W-1:0] fetch_pc
);

    fetch_state_t      r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_instr;
    logic [ADDR_W-1:0] r_next_pc;
    logic              r_valid;
    logic [ADDR_W-1:0] w_pc_next;
    logic [ADDR_W-1:0] w_redirect_pc;

    // Sequential PC increment (wraps naturally) and word-aligned redirect target
    always_comb begin
        w_pc_next     = r_pc + ADDR_W'(PC_STEP);
        w_redirect_pc = redirect_pc & ~ADDR_W'(3);
    end

    // A redirect suppresses the request issued in ISSUE; reset also holds it low
    assign imem_req       = rst_n && (r_state == ISSUE) && !redirect_valid;
    assign imem_addr      = r_pc;
    assign fetch_pc       = r_pc;
    assign IF_INSTRUCTION = r_instr;
    assign IF_NEXT_PC     = r_next_pc;
    assign IF_VALID       = r_valid;

    // Fetch FSM with registered IF/ID outputs; redirect outranks every other event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ISSUE;
            r_pc      <= RESET_PC;
            r_instr   <= NOP_INSTR;
            r_next_pc <= '0;
            r_valid   <= 1'b0;
        end else if (redirect_valid) begin
            r_pc    <= w_redirect_pc;
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
            // An outstanding request with no ack yet must have its stale response drained
            r_state <= ((r_state == WAIT || r_state == DROP) && !imem_ack) ? DROP : ISSUE;
        end else begin
            case (r_state)
                ISSUE: r_state <= WAIT;
                WAIT: begin
                    if (imem_ack) begin
                        r_instr   <= imem_rdata;
                        r_next_pc <= w_pc_next;
                        r_valid   <= 1'b1;
                        r_pc      <= w_pc_next;
                        r_state   <= HOLD;
                    end
                end
                HOLD: begin
                    if (!id_stall) begin
                        r_instr <= NOP_INSTR;
                        r_valid <= 1'b0;
                        r_state <= ISSUE;
                    end
                end
                DROP: begin
                    if (imem_ack) r_state <= ISSUE;
                end
                default: r_state <= ISSUE;
            endcase
        end
    end

    // Memory must never respond when no request is outstanding
    a_ack_protocol: assert property (@(posedge clk) disable iff (!rst_n)
        !(imem_ack && (r_state == ISSUE || r_state == HOLD)));

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: scoreboard bench for the instruction-fetch unit with a latency-programmable memory model
module tb_if_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        id_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] IF_INSTRUCTION;
    logic [31:0] IF_NEXT_PC;
    logic        IF_VALID;
    logic [31:0] fetch_pc;

    int          n_chk;
    int          n_fail;
    logic [63:0] q[$];
    logic [63:0] exp;

    logic        m_pend;
    int          m_cnt;
    int          m_lat;
    logic [31:0] m_addr;
    logic        m_ovr_en;
    logic [31:0] m_ovr;
    logic        m_discard;

    if_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0), .PC_STEP(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .id_stall(id_stall),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .IF_INSTRUCTION(IF_INSTRUCTION),
        .IF_NEXT_PC(IF_NEXT_PC),
        .IF_VALID(IF_VALID),
        .fetch_pc(fetch_pc)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Memory model: acks m_lat cycles after a request and pushes the expected IF/ID contents
    initial begin
        imem_ack   = 0;
        imem_rdata = 0;
        m_pend     = 0;
        m_cnt      = 0;
        m_addr     = 0;
        forever begin
            @(negedge clk);
            imem_ack = 0;
            if (m_pend) begin
                if (m_cnt == 0) begin
                    imem_ack   = 1;
                    imem_rdata = m_ovr_en ? m_ovr : 32'h1111_0000 + m_addr;
                    if (!m_discard) q.push_back({imem_rdata, m_addr + 32'd4});
                    m_pend    = 0;
                    m_ovr_en  = 0;
                    m_discard = 0;
                end else begin
                    m_cnt--;
                end
            end
            #2;
            if (!rst_n) begin
                m_pend   = 0;
                imem_ack = 0;
            end else if (imem_req) begin
                m_pend = 1;
                m_cnt  = m_lat - 1;
                m_addr = imem_addr;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n          = 0;
        redirect_valid = 0;
        id_stall       = 0;
        m_lat          = 1;
        m_ovr_en       = 0;
        m_discard      = 0;
        @(negedge clk);
        q.delete();
        rst_n = 1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        @(negedge clk);
        q.delete();
        rst_n = 1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        n_chk++; if (IF_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", IF_VALID); end
        n_chk++; if (IF_INSTRUCTION !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h expected 0", IF_INSTRUCTION); end
        n_chk++; if (IF_NEXT_PC !== 32'h0) begin n_fail++; $display("FAIL reset_next_pc: got %h expected 0", IF_NEXT_PC); end
        n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", imem_req); end
        n_chk++; if (fetch_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected 0", fetch_pc); end
    endtask

    task automatic test_sequential();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            n_chk++; if (imem_req !== 1'(i % 3 == 0)) begin n_fail++; $display("FAIL seq_req[%0d]: got %b expected %b", i, imem_req, i % 3 == 0); end
            if (i % 3 == 0) begin
                n_chk++; if (imem_addr !== 32'(4 * (i / 3))) begin n_fail++; $display("FAIL seq_addr[%0d]: got %h expected %h", i, imem_addr, 4 * (i / 3)); end
            end
            n_chk++; if (IF_VALID !== 1'(i % 3 == 2)) begin n_fail++; $display("FAIL seq_valid[%0d]: got %b expected %b", i, IF_VALID, i % 3 == 2); end
            if (i == 2) begin
                n_chk++; if ({IF_INSTRUCTION, IF_NEXT_PC} !== {32'h1111_0000, 32'h4}) begin n_fail++; $display("FAIL seq_first: got %h/%h expected 11110000/00000004", IF_INSTRUCTION, IF_NEXT_PC); end
            end
            if (IF_VALID) begin
                n_chk++;
                if (q.size() == 0) begin n_fail++; $display("FAIL seq_sb: got valid %h with empty scoreboard", IF_INSTRUCTION); end
                else begin
                    exp = q.pop_front();
                    if ({IF_INSTRUCTION, IF_NEXT_PC} !== exp) begin n_fail++; $display("FAIL seq_sb: got %h/%h expected %h/%h", IF_INSTRUCTION, IF_NEXT_PC, exp[63:32], exp[31:0]); end
                end
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        id_stall = 1;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 6) id_stall = 0;
            #1;
            if (i >= 2 && i <= 6) begin
                n_chk++; if ({IF_VALID, IF_INSTRUCTION, IF_NEXT_PC} !== {1'b1, 32'h1111_0000, 32'h4}) begin n_fail++; $display("FAIL stall_hold[%0d]: got %b/%h/%h expected 1/11110000/00000004", i, IF_VALID, IF_INSTRUCTION, IF_NEXT_PC); end
                n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req[%0d]: got %b expected 0", i, imem_req); end
            end
            if (i == 2) begin
                n_chk++;
                if (q.size() == 0) begin n_fail++; $display("FAIL stall_sb: got valid with empty scoreboard"); end
                else begin
                    exp = q.pop_front();
                    if ({IF_INSTRUCTION, IF_NEXT_PC} !== exp) begin n_fail++; $display("FAIL stall_sb: got %h/%h expected %h/%h", IF_INSTRUCTION, IF_NEXT_PC, exp[63:32], exp[31:0]); end
                end
            end
            if (i == 7) begin
                n_chk++; if ({imem_req, imem_addr} !== {1'b1, 32'h4}) begin n_fail++; $display("FAIL stall_resume: got %b/%h expected 1/00000004", imem_req, imem_addr); end
                n_chk++; if (IF_VALID !== 1'b0) begin n_fail++; $display("FAIL stall_release_valid: got %b expected 0", IF_VALID); end
            end
        end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        m_lat     = 3;
        m_ovr_en  = 1;
        m_ovr     = 32'hDEAD_BEEF;
        m_discard = 1;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge clk);
            redirect_valid = (i == 1);
            redirect_pc    = 32'h0000_0103;
            #1;
            n_chk++; if (IF_INSTRUCTION === 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rdw_stale[%0d]: got %h expected not DEADBEEF", i, IF_INSTRUCTION); end
            n_chk++; if (IF_VALID !== 1'(i == 8)) begin n_fail++; $display("FAIL rdw_valid[%0d]: got %b expected %b", i, IF_VALID, i == 8); end
            if (i >= 1 && i <= 3) begin
                n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rdw_req[%0d]: got %b expected 0", i, imem_req); end
            end
            if (i == 2) begin
                n_chk++; if (fetch_pc !== 32'h100) begin n_fail++; $display("FAIL rdw_pc: got %h expected 00000100", fetch_pc); end
            end
            if (i == 4) begin
                n_chk++; if ({imem_req, imem_addr} !== {1'b1, 32'h100}) begin n_fail++; $display("FAIL rdw_target: got %b/%h expected 1/00000100", imem_req, imem_addr); end
            end
            if (i == 8) begin
                n_chk++; if (IF_INSTRUCTION !== 32'h1111_0100) begin n_fail++; $display("FAIL rdw_instr: got %h expected 11110100", IF_INSTRUCTION); end
            end
            if (IF_VALID) begin
                n_chk++;
                if (q.size() == 0) begin n_fail++; $display("FAIL rdw_sb: got valid %h with empty scoreboard", IF_INSTRUCTION); end
                else begin
                    exp = q.pop_front();
                    if ({IF_INSTRUCTION, IF_NEXT_PC} !== exp) begin n_fail++; $display("FAIL rdw_sb: got %h/%h expected %h/%h", IF_INSTRUCTION, IF_NEXT_PC, exp[63:32], exp[31:0]); end
                end
            end
        end
        redirect_valid = 0;
    endtask

    task automatic test_redirect_ack();
        do_reset();
        m_discard = 1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            redirect_valid = (i == 1);
            redirect_pc    = 32'h0000_0200;
            #1;
            n_chk++; if (IF_VALID !== 1'(i == 4)) begin n_fail++; $display("FAIL rda_valid[%0d]: got %b expected %b", i, IF_VALID, i == 4); end
            if (i == 2) begin
                n_chk++; if ({imem_req, imem_addr} !== {1'b1, 32'h200}) begin n_fail++; $display("FAIL rda_target: got %b/%h expected 1/00000200", imem_req, imem_addr); end
            end
            if (i == 4) begin
                n_chk++; if ({IF_INSTRUCTION, IF_NEXT_PC} !== {32'h1111_0200, 32'h204}) begin n_fail++; $display("FAIL rda_instr: got %h/%h expected 11110200/00000204", IF_INSTRUCTION, IF_NEXT_PC); end
            end
            if (IF_VALID) begin
                n_chk++;
                if (q.size() == 0) begin n_fail++; $display("FAIL rda_sb: got valid %h with empty scoreboard", IF_INSTRUCTION); end
                else begin
                    exp = q.pop_front();
                    if ({IF_INSTRUCTION, IF_NEXT_PC} !== exp) begin n_fail++; $display("FAIL rda_sb: got %h/%h expected %h/%h", IF_INSTRUCTION, IF_NEXT_PC, exp[63:32], exp[31:0]); end
                end
            end
        end
        redirect_valid = 0;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            redirect_valid = (i == 0);
            redirect_pc    = 32'hFFFF_FFFF;
            #1;
            if (i == 0) begin
                n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL wrap_req_redirect: got %b expected 0", imem_req); end
            end
            if (i == 1) begin
                n_chk++; if ({imem_req, imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin n_fail++; $display("FAIL wrap_addr: got %b/%h expected 1/FFFFFFFC", imem_req, imem_addr); end
            end
            if (i == 3) begin
                n_chk++; if ({IF_VALID, IF_INSTRUCTION, IF_NEXT_PC} !== {1'b1, 32'h1110_FFFC, 32'h0}) begin n_fail++; $display("FAIL wrap_next_pc: got %b/%h/%h expected 1/1110FFFC/00000000", IF_VALID, IF_INSTRUCTION, IF_NEXT_PC); end
            end
            if (i == 4) begin
                n_chk++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL wrap_next_addr: got %b/%h expected 1/00000000", imem_req, imem_addr); end
            end
            if (IF_VALID) begin
                n_chk++;
                if (q.size() == 0) begin n_fail++; $display("FAIL wrap_sb: got valid %h with empty scoreboard", IF_INSTRUCTION); end
                else begin
                    exp = q.pop_front();
                    if ({IF_INSTRUCTION, IF_NEXT_PC} !== exp) begin n_fail++; $display("FAIL wrap_sb: got %h/%h expected %h/%h", IF_INSTRUCTION, IF_NEXT_PC, exp[63:32], exp[31:0]); end
                end
            end
        end
        redirect_valid = 0;
    endtask

    task automatic test_async_reset();
        do_reset();
        m_lat = 3;
        #1;
        n_chk++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL ar_issue_req: got %b expected 1", imem_req); end
        #2 rst_n = 0;
        #1;
        n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL ar_issue_gate: got %b expected 0", imem_req); end
        release_reset();
        #1;
        n_chk++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL ar_restart1: got %b/%h expected 1/00000000", imem_req, imem_addr); end
        @(negedge clk);
        #3 rst_n = 0;
        #1;
        n_chk++; if ({imem_req, IF_VALID, fetch_pc} !== {1'b0, 1'b0, 32'h0}) begin n_fail++; $display("FAIL ar_wait: got req %b valid %b pc %h expected 0/0/00000000", imem_req, IF_VALID, fetch_pc); end
        release_reset();
        m_lat = 1;
        #1;
        n_chk++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL ar_restart2: got %b/%h expected 1/00000000", imem_req, imem_addr); end
        repeat (2) @(negedge clk);
        #1;
        n_chk++; if ({IF_VALID, IF_INSTRUCTION, fetch_pc} !== {1'b1, 32'h1111_0000, 32'h4}) begin n_fail++; $display("FAIL ar_hold_pre: got %b/%h/%h expected 1/11110000/00000004", IF_VALID, IF_INSTRUCTION, fetch_pc); end
        #2 rst_n = 0;
        #1;
        n_chk++; if ({IF_VALID, IF_INSTRUCTION, IF_NEXT_PC, fetch_pc} !== {1'b0, 32'h0, 32'h0, 32'h0}) begin n_fail++; $display("FAIL ar_hold: got %b/%h/%h/%h expected 0/0/0/0", IF_VALID, IF_INSTRUCTION, IF_NEXT_PC, fetch_pc); end
        release_reset();
        #1;
        n_chk++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL ar_restart3: got %b/%h expected 1/00000000", imem_req, imem_addr); end
    endtask

    initial begin
        n_chk          = 0;
        n_fail         = 0;
        rst_n          = 0;
        id_stall       = 0;
        redirect_valid = 0;
        redirect_pc    = 0;
        m_lat          = 1;
        m_ovr_en       = 0;
        m_ovr          = 0;
        m_discard      = 0;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_redirect_ack();
        test_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
